// File: rtl/alu_pkg.sv
// Shared widths, opcode map, FSM encoding and the queued command layout
// for the ALU sequencer.
package alu_pkg;

   localparam int ALU_W = 8;
   localparam int SEL_W = 4;

   localparam logic [SEL_W-1:0] OP_ZERO    = 4'b0000;
   localparam logic [SEL_W-1:0] OP_PASS_A  = 4'b0001;
   localparam logic [SEL_W-1:0] OP_PASS_B  = 4'b0010;
   localparam logic [SEL_W-1:0] OP_NEG_A   = 4'b0011;
   localparam logic [SEL_W-1:0] OP_NEG_B   = 4'b0100;
   localparam logic [SEL_W-1:0] OP_ROR_A   = 4'b0101;
   localparam logic [SEL_W-1:0] OP_ROR_B   = 4'b0110;
   localparam logic [SEL_W-1:0] OP_LT      = 4'b0111;
   localparam logic [SEL_W-1:0] OP_BITWISE = 4'b1000;
   localparam logic [SEL_W-1:0] OP_NOT_A   = 4'b1001;
   localparam logic [SEL_W-1:0] OP_NOT_B   = 4'b1010;
   localparam logic [SEL_W-1:0] OP_SUB     = 4'b1011;
   localparam logic [SEL_W-1:0] OP_ADD     = 4'b1100;
   localparam logic [SEL_W-1:0] OP_ONES    = 4'b1111;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_EXEC = 2'b01;
   localparam logic [1:0] ST_HOLD = 2'b10;

   typedef struct packed {
      logic [SEL_W-1:0] op;
      logic             use_acc;
      logic [ALU_W-1:0] a;
      logic [ALU_W-1:0] b;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   function automatic logic [ALU_W-1:0] pick_a(input logic use_acc,
                                               input logic [ALU_W-1:0] acc,
                                               input logic [ALU_W-1:0] a);
      return use_acc ? acc : a;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with one wrap bit per pointer so full and empty are
// distinguished without a separate occupancy counter.
module cmd_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

   // pointer advance; reset empties the queue
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         else           wr_ptr_r <= wr_ptr_r;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         else           rd_ptr_r <= rd_ptr_r;
      end
   end

   // entry storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands, issues them one at a time to an external combinational
// ALU, and hands each result to the consumer with valid/ready.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [SEL_W-1:0] cmd_op,
   input  logic             cmd_use_acc,
   input  logic [ALU_W-1:0] cmd_a,
   input  logic [ALU_W-1:0] cmd_b,
   output logic [SEL_W-1:0] alu_select,
   output logic [ALU_W-1:0] alu_a,
   output logic [ALU_W-1:0] alu_b,
   input  logic [ALU_W-1:0] alu_x,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ALU_W-1:0] res_data,
   output logic [ALU_W-1:0] acc,
   output logic             busy
);

   logic [1:0]       state_r;
   logic [SEL_W-1:0] sel_r;
   logic [ALU_W-1:0] a_r;
   logic [ALU_W-1:0] b_r;
   logic [ALU_W-1:0] res_data_r;
   logic [ALU_W-1:0] acc_r;
   logic             res_valid_r;

   cmd_t             in_s;
   cmd_t             head_s;
   logic             push_s;
   logic             pop_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;

   assign cmd_ready = ~fifo_full_s & ~rst;
   assign push_s    = cmd_valid & cmd_ready;
   assign in_s      = {cmd_op, cmd_use_acc, cmd_a, cmd_b};

   cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata (in_s),
      .pop   (pop_s),
      .rdata (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // head is consumed when idle, or when the held result is being accepted
   always_comb begin
      pop_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!fifo_empty_s) pop_s = 1'b1;
            else               pop_s = 1'b0;
         end
         ST_HOLD: begin
            if (res_ready && !fifo_empty_s) pop_s = 1'b1;
            else                            pop_s = 1'b0;
         end
         default: pop_s = 1'b0;
      endcase
   end

   // issue / execute / hold sequencing; acc is already current at a pop edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         sel_r       <= {SEL_W{1'b0}};
         a_r         <= {ALU_W{1'b0}};
         b_r         <= {ALU_W{1'b0}};
         res_data_r  <= {ALU_W{1'b0}};
         acc_r       <= {ALU_W{1'b0}};
         res_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  sel_r   <= head_s.op;
                  a_r     <= pick_a(head_s.use_acc, acc_r, head_s.a);
                  b_r     <= head_s.b;
                  state_r <= ST_EXEC;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               res_data_r  <= alu_x;
               acc_r       <= alu_x;
               res_valid_r <= 1'b1;
               state_r     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (res_ready) begin
                  res_valid_r <= 1'b0;
                  if (pop_s) begin
                     sel_r   <= head_s.op;
                     a_r     <= pick_a(head_s.use_acc, acc_r, head_s.a);
                     b_r     <= head_s.b;
                     state_r <= ST_EXEC;
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end else begin
                  state_r <= ST_HOLD;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               res_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign alu_select = sel_r;
   assign alu_a      = a_r;
   assign alu_b      = b_r;
   assign res_data   = res_data_r;
   assign res_valid  = res_valid_r;
   assign acc        = acc_r;
   assign busy       = (state_r != ST_IDLE) | ~fifo_empty_s;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised scoreboard bench: a command-order reference model predicts every
// result; a separate monitor compares each accepted result beat.
module tb_alu_sequencer;
   import alu_pkg::*;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic       cmd_use_acc;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [3:0] alu_select;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_x;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [7:0] acc;
   logic       busy;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] r;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] model_acc;
   int         n_checks;
   int         n_fail;
   int         cyc;
   logic       bp_phase;

   alu_sequencer #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_x(alu_x),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .acc(acc), .busy(busy)
   );

   // environment ALU; code 1101 is unassigned and answers 8'h81
   function automatic logic [7:0] alu_fn(input logic [3:0] s, input logic [7:0] a,
                                         input logic [7:0] b);
      case (s)
         OP_ZERO:    return 8'h00;
         OP_PASS_A:  return a;
         OP_PASS_B:  return b;
         OP_NEG_A:   return 8'h00 - a;
         OP_NEG_B:   return 8'h00 - b;
         OP_ROR_A:   return {a[0], a[7:1]};
         OP_ROR_B:   return {b[0], b[7:1]};
         OP_LT:      return (a < b) ? 8'h01 : 8'h00;
         OP_BITWISE: return a & b;
         OP_NOT_A:   return ~a;
         OP_NOT_B:   return ~b;
         OP_SUB:     return a - b;
         OP_ADD:     return a + b;
         4'b1101:    return 8'h81;
         4'b1110:    return a ^ b;
         OP_ONES:    return 8'hFF;
         default:    return 8'h00;
      endcase
   endfunction

   assign alu_x = alu_fn(alu_select, alu_a, alu_b);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // reference: commands complete in order, so acc at issue is the previous result
   task automatic push_model(input logic [3:0] op, input logic use_acc,
                             input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.sel = op;
      e.a   = use_acc ? model_acc : a;
      e.b   = b;
      e.r   = alu_fn(op, e.a, b);
      model_acc = e.r;
      sb.push_back(e);
   endtask

   // monitor: a beat is accepted at the next rising edge when valid & ready
   initial begin : monitor
      exp_t e;
      int   prev_cyc;
      logic have_prev;
      have_prev = 1'b0;
      prev_cyc  = 0;
      forever begin
         @(negedge clk);
         if (!bp_phase) have_prev = 1'b0;
         if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL res_unexpected: got data %0h expected no result", res_data);
            end else begin
               e = sb.pop_front();
               check("res_data", 32'(res_data), 32'(e.r));
               check("res_acc", 32'(acc), 32'(e.r));
               check("res_sel", 32'(alu_select), 32'(e.sel));
               check("res_alu_a", 32'(alu_a), 32'(e.a));
               check("res_alu_b", 32'(alu_b), 32'(e.b));
               if (bp_phase && have_prev) check("res_spacing", 32'(cyc - prev_cyc), 32'd2);
               prev_cyc  = cyc;
               have_prev = 1'b1;
            end
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic use_acc,
                       input logic [7:0] a, input logic [7:0] b);
      int   waited;
      logic ok;
      waited = 0;
      ok = 1'b0;
      cmd_valid = 1'b1; cmd_op = op; cmd_use_acc = use_acc; cmd_a = a; cmd_b = b;
      while (!ok && waited < 200) begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      cmd_valid = 1'b0;
      if (ok) push_model(op, use_acc, a, b);
      else begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: got cmd_ready %0b expected 1", cmd_ready);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic latency(input logic [7:0] v);
      res_ready = 1'b1;
      cmd_valid = 1'b1; cmd_op = OP_PASS_A; cmd_use_acc = 1'b0; cmd_a = v; cmd_b = ~v;
      @(negedge clk);
      check("lat_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      push_model(OP_PASS_A, 1'b0, v, ~v);
      check("lat_e0_valid", 32'(res_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_e1_valid", 32'(res_valid), 32'd0);
      check("lat_e1_sel", 32'(alu_select), 32'(OP_PASS_A));
      check("lat_e1_alu_a", 32'(alu_a), 32'(v));
      @(posedge clk); #1;
      check("lat_e2_valid", 32'(res_valid), 32'd1);
      check("lat_e2_data", 32'(res_data), 32'(v));
      check("lat_e2_acc", 32'(acc), 32'(v));
      @(posedge clk); #1;
      check("lat_single_beat", 32'(res_valid), 32'd0);
   endtask

   task automatic fill(input int offers, output int accepted);
      logic ok;
      accepted = 0;
      for (int i = 0; i < offers; i++) begin
         cmd_valid = 1'b1;
         cmd_op = 4'($urandom_range(0, 15));
         cmd_use_acc = 1'($urandom_range(0, 1));
         cmd_a = 8'($urandom_range(0, 255));
         cmd_b = 8'($urandom_range(0, 255));
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk); #1;
         if (ok) begin
            push_model(cmd_op, cmd_use_acc, cmd_a, cmd_b);
            accepted++;
         end
      end
      cmd_valid = 1'b0;
   endtask

   initial begin : stim
      int   accepted;
      int   sent;
      logic pend;
      logic ok;
      n_checks = 0; n_fail = 0; cyc = 0; bp_phase = 1'b0; model_acc = 8'h00;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_use_acc = 1'b0;
      cmd_a = 8'h00; cmd_b = 8'h00; res_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_acc", 32'(acc), 32'h00);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_alu_select", 32'(alu_select), 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      latency(8'h5A);

      send(OP_PASS_A, 1'b0, 8'h0F, 8'h3C);
      send(OP_NOT_A, 1'b1, 8'h33, 8'h55);
      drain();
      check("chain_acc", 32'(acc), 32'hF0);
      check("chain_busy", 32'(busy), 32'd0);

      send(4'b1101, 1'b0, 8'h12, 8'h34);
      drain();
      check("unassigned_acc", 32'(acc), 32'h81);

      res_ready = 1'b0;
      fill(6, accepted);
      check("bp_accepted", 32'(accepted), 32'd5);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      bp_phase = 1'b1;
      res_ready = 1'b1;
      drain();
      bp_phase = 1'b0;
      check("bp_acc", 32'(acc), 32'(model_acc));

      res_ready = 1'b0;
      fill(5, accepted);
      check("mid_accepted", 32'(accepted), 32'd5);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      rst = 1'b1;
      sb.delete();
      model_acc = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("mid_no_valid", 32'(res_valid), 32'd0);
      end
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_acc", 32'(acc), 32'h00);
      latency(8'hC3);
      drain();

      sent = 0;
      pend = 1'b0;
      for (int c = 0; c < 3000 && sent < 150; c++) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            cmd_op = 4'($urandom_range(0, 15));
            cmd_use_acc = 1'($urandom_range(0, 1));
            cmd_a = 8'($urandom_range(0, 255));
            cmd_b = 8'($urandom_range(0, 255));
            pend = 1'b1;
         end
         cmd_valid = pend;
         res_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         ok = cmd_valid & cmd_ready;
         @(posedge clk); #1;
         if (ok) begin
            push_model(cmd_op, cmd_use_acc, cmd_a, cmd_b);
            pend = 1'b0;
            sent++;
         end
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      drain();
      check("rand_sent", 32'(sent), 32'd150);
      check("rand_final_acc", 32'(acc), 32'(model_acc));
      check("rand_final_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: command queue depth in entries (power of two, >=2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  command queue can accept.
REQ-006 cmd_op  input  4  ALU select code to issue.
REQ-007 cmd_use_acc  input  1  1: ALU A operand = accumulator at issue time; 0: A = cmd_a.
REQ-008 cmd_a  input  8  A operand.
REQ-009 cmd_b  input  8  B operand.
REQ-010 alu_select  output  4  registered select code driven to the combinational ALU.
REQ-011 alu_a  output  8  registered ALU A operand.
REQ-012 alu_b  output  8  registered ALU B operand.
REQ-013 alu_x  input  8  combinational ALU result.
REQ-014 res_valid  output  1  result available.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 res_data  output  8  captured result.
REQ-017 acc  output  8  accumulator; equals last captured result.
REQ-018 busy  output  1  high when FSM is not IDLE or the queue is non-empty.

Function
REQ-019 cmd_ready SHALL equal (queue not full) and SHALL be 0 while rst is high; a push occurs on an edge with cmd_valid & cmd_ready.
REQ-020 The queue SHALL store {cmd_op, cmd_use_acc, cmd_a, cmd_b} in FIFO order; a push when full SHALL be impossible, even on a pop edge.
REQ-021 FSM states: IDLE, EXEC, HOLD.
REQ-022 IDLE: at an edge with queue non-empty, pop head, load alu_select=op, alu_a=(use_acc ? acc : a), alu_b=b, go EXEC.
REQ-023 EXEC: lasts exactly one cycle; at its closing edge capture alu_x into res_data and acc, set res_valid=1, go HOLD.
REQ-024 HOLD: res_valid, res_data, alu_* held stable until res_ready=1; at that edge clear res_valid and go EXEC with a pop if the queue is non-empty (same load rule as REQ-022), else go IDLE.
REQ-025 Latency: a command pushed at edge E0 into an empty queue with FSM IDLE SHALL raise res_valid after edge E2.
REQ-026 cmd_use_acc SHALL use the accumulator value current at the pop edge, including a result captured at the immediately preceding edge.
REQ-027 Every 4-bit opcode SHALL be issued unaltered; the sequencer does not decode or reject codes.
REQ-028 Results SHALL leave in command order; none dropped or duplicated.

Reset
REQ-029 While rst is high, at each edge: state=IDLE, queue empty, acc=0x00, res_data=0x00, res_valid=0, alu_select=4'b0000, alu_a=0x00, alu_b=0x00.
REQ-030 Reset mid-operation (any state) SHALL discard queued and in-flight commands; the first post-reset command behaves per REQ-025.

Structure
REQ-031 Package alu_pkg SHALL hold ALU_W=8, SEL_W=4, opcode constants (ZERO 0000, PASS_A 0001, PASS_B 0010, NEG_A 0011, NEG_B 0100, ROR_A 0101, ROR_B 0110, LT 0111, BITWISE 1000, NOT_A 1001, NOT_B 1010, SUB 1011, ADD 1100, ONES 1111) and the FSM state encoding.
REQ-032 The queue SHALL be a separate sub-module cmd_fifo (synchronous, parameterised width/depth, full/empty outputs).

Verification
REQ-033 Reset: hold rst 2 cycles -> acc=00, res_valid=0, alu_select=0000, busy=0; cmd_ready=1 the cycle after rst drops.
REQ-034 Single command: PASS_A, a=5A, use_acc=0, res_ready=1 -> res_data=5A, acc=5A, res_valid high after E2, single beat.
REQ-035 Chaining: PASS_A a=0F, then NOT_A use_acc=1 -> second issue drives alu_a=0F, result F0, acc=F0.
REQ-036 Backpressure: res_ready=0, offer 6 commands -> 5 accepted (1 in FSM, 4 queued), cmd_ready=0; release res_ready -> 5 results in order, one per 2 cycles.
REQ-037 Reset mid-operation: assert rst in EXEC with 3 queued -> no res_valid after reset, busy=0, acc=00.
REQ-038 Unassigned code 1101 with ALU model returning 81 -> alu_select=1101 issued, res_data=81.
